chi_iota_stage: RTL and testbench

Streaming nonlinear stage that sits directly downstream of the permute stage in the matrix encoder round. It consumes the 25-bit slice lines produced by permute, one per handshake, for a frame of `SLICES` slices. For each slice it applies the row-wise chi transform and, optionally, the iota round-constant injection. Results are emitted through a single registered output stage with valid/ready flow control to the next round stage.

---
 rtl/chi_iota_stage_if.sv | 25 ++
 rtl/chi_iota_stage.sv | 123 ++++++++++++
 tb/tb_chi_iota_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/chi_iota_stage_if.sv
// Line stream bus for chi_iota_stage: upstream line handshake plus the registered
// downstream line with its slice index and end-of-frame marker.
interface chi_iota_stage_if #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned CNT_W  = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_line;
  logic             out_valid;
  logic             out_ready;
  logic [24:0]      out_line;
  logic             out_last;
  logic [CNT_W-1:0] slice_idx;

  modport slave (
    input  in_valid, in_line, out_ready,
    output in_ready, out_valid, out_line, out_last, slice_idx
  );

  modport master (
    output in_valid, in_line, out_ready,
    input  in_ready, out_valid, out_line, out_last, slice_idx
  );
endinterface

// File: rtl/chi_iota_stage.sv
// Streaming chi (+ optional iota) stage over a frame of SLICES 25-bit slice lines.
// Define CHI_IOTA_STAGE_IOTA_EN to XOR the latched round-constant bit into bit 0.
module chi_iota_stage #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SLICES-1:0] round_const,
  chi_iota_stage_if.slave   bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             in_rdy;
  logic             accept;
  logic             out_hs;
  logic             cnt_last;
  logic [24:0]      chi_line;
  logic [24:0]      next_line;

  assign out_hs   = bus.out_valid & bus.out_ready;
  assign accept   = bus.in_valid & in_rdy;
  assign cnt_last = (cnt == CNT_W'(SLICES - 1));
  assign busy     = (state != IDLE);
  assign bus.in_ready = in_rdy;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_rdy = ~bus.out_valid | bus.out_ready;
        if (bus.in_valid & in_rdy & cnt_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_hs & bus.out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) & out_hs & bus.out_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == IDLE) && start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Row-wise chi: each bit XORed with (~next & next-next) within its 5-bit row.
  always_comb begin
    chi_line = '0;
    for (int unsigned y = 0; y < 5; y++) begin
      for (int unsigned x = 0; x < 5; x++) begin
        chi_line[5*y+x] = bus.in_line[5*y+x] ^
                          (~bus.in_line[5*y+((x+1)%5)] & bus.in_line[5*y+((x+2)%5)]);
      end
    end
  end

`ifdef CHI_IOTA_STAGE_IOTA_EN
  logic [SLICES-1:0] rc_q;
  logic [SLICES-1:0] rc_sh;
  logic              unused_rc_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q <= '0;
    end else if ((state == IDLE) && start) begin
      rc_q <= round_const;
    end
  end

  assign rc_sh        = rc_q >> cnt;
  assign next_line    = {chi_line[24:1], chi_line[0] ^ rc_sh[0]};
  assign unused_rc_sh = ^rc_sh[SLICES-1:1];
`else
  logic unused_rc;

  assign next_line = chi_line;
  assign unused_rc = ^round_const;
`endif

  // A simultaneous accept and output handshake reloads the register with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_line  <= '0;
      bus.out_last  <= 1'b0;
      bus.slice_idx <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_line  <= next_line;
      bus.out_last  <= cnt_last;
      bus.slice_idx <= cnt;
    end else if (out_hs) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chi_iota_stage.sv
// Directed bench for chi_iota_stage: chi vectors, full frames, backpressure,
// iota round constant, mid-frame reset and ignored start/in_valid.
module tb_chi_iota_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] round_const;
  logic        busy;
  logic        done;

  chi_iota_stage_if #(.SLICES(64), .CNT_W(7)) bus ();

  chi_iota_stage #(.SLICES(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .round_const (round_const),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

`ifdef CHI_IOTA_STAGE_IOTA_EN
  localparam logic IOTA_ON = 1'b1;
`else
  localparam logic IOTA_ON = 1'b0;
`endif

  typedef struct {
    logic [24:0] line;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          nchk;
  int          nerr;
  int          model_idx;
  logic [63:0] model_rc;
  logic [24:0] held_line;
  logic [6:0]  held_idx;

  always #5 clk = ~clk;

  function automatic logic [24:0] chi_ref(input logic [24:0] a);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
    return r;
  endfunction

  function automatic logic [24:0] rnd25();
    return 25'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any output handshake, model any accept, then advance to edge+1.
  task automatic cycle();
    exp_t e;
    logic [24:0] l;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      nchk++;
      assert (exp_q.size() != 0) else begin
        nerr++;
        $error("FAIL out_unexpected observed=valid_line expected=no_line");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_line", 64'(bus.out_line), 64'(e.line));
        chk("slice_idx", 64'(bus.slice_idx), 64'(e.idx));
        chk("out_last", 64'(bus.out_last), 64'(e.last));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      l = chi_ref(bus.in_line);
      if (IOTA_ON) l[0] = l[0] ^ model_rc[model_idx];
      exp_q.push_back('{line: l, idx: 7'(model_idx), last: (model_idx == 63)});
      model_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] rc);
    start = 1'b1;
    round_const = rc;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    round_const = '0;
    model_rc = rc;
    model_idx = 0;
    chk("run_busy", 64'(busy), 64'd1);
  endtask

  task automatic finish_frame();
    bus.in_valid = 1'b1;
    bus.in_line = 25'h1555555;
    start = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_no_done", 64'(done), 64'd0);
    cycle();
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_in_ready_after", 64'(bus.in_ready), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    bus.in_valid = 1'b0;
    cycle();
    chk("done_clear", 64'(done), 64'd0);
  endtask

  task automatic chk_reset_values();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_line", 64'(bus.out_line), 64'd0);
    chk("rst_slice_idx", 64'(bus.slice_idx), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    model_idx = 0;
    model_rc = '0;
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    round_const = '0;
    bus.in_valid = 1'b0;
    bus.in_line = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    chk_reset_values();
    rst = 1'b0;
    cycle();

    // Frame 1: chi directed vectors then random lines; start during RUN ignored
    do_start(64'hDEADBEEF_12345678);
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_line = (i == 0) ? 25'h0 : (i == 1) ? 25'h1FFFFFF : (i == 2) ? 25'h0000002 : rnd25();
      start = (i == 10);
      if (i == 1) chk("chi_zero", 64'(bus.out_line), 64'h0);
      if (i == 2) chk("chi_ones", 64'(bus.out_line), 64'h1FFFFFF);
      if (i == 3) chk("chi_bit1", 64'(bus.out_line), 64'h0000012);
      if (i == 3) chk("first_idx", 64'(bus.slice_idx), 64'd2);
      cycle();
    end
    finish_frame();

    // Frame 2: iota with all-zero lines, RC bits 0 and 63 set
    do_start(64'h8000000000000001);
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_line = '0;
      if (i == 1) chk("iota_slice0", 64'(bus.out_line), 64'(IOTA_ON));
      if (i == 2) chk("iota_slice1", 64'(bus.out_line), 64'h0);
      cycle();
    end
    chk("iota_slice63", 64'(bus.out_line), 64'(IOTA_ON));
    chk("iota_last", 64'(bus.out_last), 64'd1);
    finish_frame();

    // Frame 3: 5-cycle backpressure at slice 20, then reset at slice 30
    do_start(64'h0123456789ABCDEF);
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1;
      bus.in_line = rnd25();
      if (i == 20) begin
        bus.out_ready = 1'b0;
        #1;
        held_line = bus.out_line;
        held_idx = bus.slice_idx;
        for (int k = 0; k < 5; k++) begin
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
          chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
          chk("bp_out_line", 64'(bus.out_line), 64'(held_line));
          chk("bp_slice_idx", 64'(bus.slice_idx), 64'(held_idx));
          cycle();
        end
        bus.out_ready = 1'b1;
      end
      cycle();
    end
    chk("pre_rst_idx", 64'(bus.slice_idx), 64'd29);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("post_rst_no_done", 64'(done), 64'd0);
      chk("post_rst_idle", 64'(busy), 64'd0);
    end

    // Frame 4: fresh frame after reset restarts at slice 0
    do_start(64'hFFFF0000FFFF0000);
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_line = rnd25();
      if (i == 1) chk("restart_idx", 64'(bus.slice_idx), 64'd0);
      cycle();
    end
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
